// File: rtl/urv_dbg_ctrl.sv
// ---------------------------------------------------------------------------
// urv_dbg_ctrl
//   Debug access sequencer for the uRV core. Takes one debug command at a
//   time from the debug bus-slave front end, runs it against the core and
//   returns exactly one response (data + error flag) per command.
//   Commands: NOP, HALT, RESUME, RF_RD, RF_WR, CSR_RD, CSR_WR (op 7 reserved).
//   Register-file and CSR accesses are only performed while the core is
//   halted and a halt is being requested by this block.
//
// Parameters
//   HALT_TIMEOUT  cycles to wait for halted_i to change (1..255)
//
// Ports
//   clk_i, rst_i            clock, async active-high reset
//   cmd_valid_i/ready_o     command handshake (ready only in IDLE)
//   cmd_op_i/addr_i/wdata_i command fields
//   rsp_valid_o             one-cycle response pulse
//   rsp_rdata_o             last read data (held between read responses)
//   rsp_err_o               error flag, qualified by rsp_valid_o
//   halt_req_o, halted_i    halt/resume handshake with the core
//   rf_*                    register-file debug port (1-cycle read latency)
//   csr_*                   CSR debug port (1-cycle read latency)
//   busy_o                  sequencer not idle
// ---------------------------------------------------------------------------
module urv_dbg_ctrl #(
   parameter int unsigned HALT_TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [2:0]  cmd_op_i,
   input  logic [11:0] cmd_addr_i,
   input  logic [31:0] cmd_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        halt_req_o,
   input  logic        halted_i,
   output logic [4:0]  rf_addr_o,
   output logic        rf_write_o,
   output logic [31:0] rf_wd_o,
   input  logic [31:0] rf_rd_i,
   output logic [11:0] csr_addr_o,
   output logic        csr_write_o,
   output logic [31:0] csr_wd_o,
   input  logic [31:0] csr_rd_i,
   output logic        busy_o
);

   localparam logic [7:0] LP_TIMEOUT = 8'(HALT_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT_WAIT,
      S_RESUME_WAIT,
      S_ACCESS,
      S_READ,
      S_RESP
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_HALT   = 3'd1,
      OP_RESUME = 3'd2,
      OP_RF_RD  = 3'd3,
      OP_RF_WR  = 3'd4,
      OP_CSR_RD = 3'd5,
      OP_CSR_WR = 3'd6,
      OP_RSVD   = 3'd7
   } op_t;

   state_t      r_state;
   state_t      w_state_nxt;
   op_t         r_op;
   op_t         w_cmd_op;
   logic        r_err;
   logic        w_err_nxt;
   logic        r_halt_req;
   logic        w_halt_req_nxt;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic [31:0] r_rdata;
   logic [31:0] w_rdata_nxt;
   logic [4:0]  r_rf_addr;
   logic [31:0] r_rf_wd;
   logic [11:0] r_csr_addr;
   logic [31:0] r_csr_wd;

   logic        w_accept;
   logic        w_cmd_rf;
   logic        w_cmd_csr;
   logic        w_cmd_wr;
   logic        w_access_bad;
   logic        w_latch_rf;
   logic        w_latch_csr;
   logic        w_rf_write;
   logic        w_csr_write;
   logic        w_rsp_valid;

   assign w_cmd_op  = op_t'(cmd_op_i);
   assign w_accept  = cmd_valid_i && (r_state == S_IDLE);
   assign w_cmd_rf  = (w_cmd_op == OP_RF_RD)  || (w_cmd_op == OP_RF_WR);
   assign w_cmd_csr = (w_cmd_op == OP_CSR_RD) || (w_cmd_op == OP_CSR_WR);
   assign w_cmd_wr  = (w_cmd_op == OP_RF_WR)  || (w_cmd_op == OP_CSR_WR);

   // Port accesses need a halted core that we are actively holding halted;
   // RF indices above 31 are rejected outright.
   assign w_access_bad = !halted_i || !r_halt_req ||
                         (w_cmd_rf && (cmd_addr_i[11:5] != 7'd0));

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next-state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_err_nxt      = r_err;
      w_halt_req_nxt = r_halt_req;
      w_cnt_nxt      = r_cnt;
      w_rdata_nxt    = r_rdata;
      w_latch_rf     = 1'b0;
      w_latch_csr    = 1'b0;
      w_rf_write     = 1'b0;
      w_csr_write    = 1'b0;
      w_rsp_valid    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_err_nxt = 1'b0;
               case (w_cmd_op)
                  OP_NOP: begin
                     w_state_nxt = S_RESP;
                  end
                  OP_RSVD: begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = S_RESP;
                  end
                  OP_HALT: begin
                     w_halt_req_nxt = 1'b1;
                     w_cnt_nxt      = '0;
                     w_state_nxt    = halted_i ? S_RESP : S_HALT_WAIT;
                  end
                  OP_RESUME: begin
                     w_halt_req_nxt = 1'b0;
                     w_cnt_nxt      = '0;
                     w_state_nxt    = halted_i ? S_RESUME_WAIT : S_RESP;
                  end
                  default: begin
                     if (w_access_bad) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_RESP;
                     end else begin
                        w_latch_rf  = w_cmd_rf;
                        w_latch_csr = w_cmd_csr;
                        w_state_nxt = S_ACCESS;
                     end
                  end
               endcase
            end
         end

         S_HALT_WAIT: begin
            if (halted_i) begin
               w_state_nxt = S_RESP;
            end else if (r_cnt == LP_TIMEOUT) begin
               // Give up: withdraw the request so the core is not left
               // with a stale halt pending.
               w_halt_req_nxt = 1'b0;
               w_err_nxt      = 1'b1;
               w_state_nxt    = S_RESP;
            end else if (r_cnt != 8'hFF) begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end

         S_RESUME_WAIT: begin
            if (!halted_i) begin
               w_state_nxt = S_RESP;
            end else if (r_cnt == LP_TIMEOUT) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_RESP;
            end else if (r_cnt != 8'hFF) begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end

         S_ACCESS: begin
            // Writes to x0 are silently dropped but still acknowledged.
            w_rf_write  = (r_op == OP_RF_WR) && (r_rf_addr != 5'd0);
            w_csr_write = (r_op == OP_CSR_WR);
            if ((r_op == OP_RF_RD) || (r_op == OP_CSR_RD)) begin
               w_state_nxt = S_READ;
            end else begin
               w_state_nxt = S_RESP;
            end
         end

         S_READ: begin
            w_rdata_nxt = (r_op == OP_RF_RD) ? rf_rd_i : csr_rd_i;
            w_state_nxt = S_RESP;
         end

         S_RESP: begin
            w_rsp_valid = 1'b1;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_op       <= OP_NOP;
         r_err      <= 1'b0;
         r_halt_req <= 1'b0;
         r_cnt      <= '0;
         r_rdata    <= '0;
         r_rf_addr  <= '0;
         r_rf_wd    <= '0;
         r_csr_addr <= '0;
         r_csr_wd   <= '0;
      end else begin
         r_err      <= w_err_nxt;
         r_halt_req <= w_halt_req_nxt;
         r_cnt      <= w_cnt_nxt;
         r_rdata    <= w_rdata_nxt;
         if (w_accept) begin
            r_op <= w_cmd_op;
         end
         // Port address/data registers only move on a granted access so
         // that rejected commands leave the debug ports untouched.
         if (w_latch_rf) begin
            r_rf_addr <= cmd_addr_i[4:0];
            if (w_cmd_wr) begin
               r_rf_wd <= cmd_wdata_i;
            end
         end
         if (w_latch_csr) begin
            r_csr_addr <= cmd_addr_i;
            if (w_cmd_wr) begin
               r_csr_wd <= cmd_wdata_i;
            end
         end
      end
   end

   assign cmd_ready_o = (r_state == S_IDLE);
   assign busy_o      = (r_state != S_IDLE);
   assign rsp_valid_o = w_rsp_valid;
   assign rsp_err_o   = w_rsp_valid && r_err;
   assign rsp_rdata_o = r_rdata;
   assign halt_req_o  = r_halt_req;
   assign rf_addr_o   = r_rf_addr;
   assign rf_wd_o     = r_rf_wd;
   assign rf_write_o  = w_rf_write;
   assign csr_addr_o  = r_csr_addr;
   assign csr_wd_o    = r_csr_wd;
   assign csr_write_o = w_csr_write;

endmodule

// File: tb/tb_urv_dbg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_urv_dbg_ctrl
//   Directed bench for urv_dbg_ctrl (HALT_TIMEOUT overridden to 4).
//   Includes a tiny core-side model: a 32-entry register file written by
//   rf_write_o and a CSR file whose read value is 0xC5A00 concatenated with
//   the CSR address, both returning data one cycle after the address.
// ---------------------------------------------------------------------------
module tb_urv_dbg_ctrl;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_HALT   = 3'd1;
   localparam logic [2:0] OP_RESUME = 3'd2;
   localparam logic [2:0] OP_RF_RD  = 3'd3;
   localparam logic [2:0] OP_RF_WR  = 3'd4;
   localparam logic [2:0] OP_CSR_RD = 3'd5;
   localparam logic [2:0] OP_CSR_WR = 3'd6;
   localparam logic [2:0] OP_RSVD   = 3'd7;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        halt_req;
   logic        halted;
   logic [4:0]  rf_addr;
   logic        rf_write;
   logic [31:0] rf_wd;
   logic [31:0] rf_rd;
   logic [11:0] csr_addr;
   logic        csr_write;
   logic [31:0] csr_wd;
   logic [31:0] csr_rd;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [31:0] rf_mem [32];

   urv_dbg_ctrl #(.HALT_TIMEOUT(4)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_op_i    (cmd_op),
      .cmd_addr_i  (cmd_addr),
      .cmd_wdata_i (cmd_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .halt_req_o  (halt_req),
      .halted_i    (halted),
      .rf_addr_o   (rf_addr),
      .rf_write_o  (rf_write),
      .rf_wd_o     (rf_wd),
      .rf_rd_i     (rf_rd),
      .csr_addr_o  (csr_addr),
      .csr_write_o (csr_write),
      .csr_wd_o    (csr_wd),
      .csr_rd_i    (csr_rd),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
   end

   // Core-side debug port model.
   always @(posedge clk) begin
      if (rf_write) rf_mem[rf_addr] <= rf_wd;
      rf_rd  <= rf_mem[rf_addr];
      csr_rd <= {20'hC5A00, csr_addr};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a command in an idle cycle; returns #1 after the accept edge
   // (i.e. in cycle 1 of the command).
   task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd);
      chk("issue_ready", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_wdata = wd;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_addr  = 12'd0;
      cmd_wdata = 32'd0;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_addr  = 12'd0;
      cmd_wdata = 32'd0;
      halted    = 1'b0;
      repeat (3) tick();

      // Reset values
      chk("rst_ready",  {31'd0, cmd_ready}, 32'd1);
      chk("rst_ctrl",   {26'd0, busy, rsp_valid, rsp_err, halt_req, rf_write, csr_write}, 32'd0);
      chk("rst_rdata",  rsp_rdata, 32'd0);
      chk("rst_rfaddr", {27'd0, rf_addr}, 32'd0);
      chk("rst_rfwd",   rf_wd, 32'd0);
      chk("rst_csraddr",{20'd0, csr_addr}, 32'd0);
      chk("rst_csrwd",  csr_wd, 32'd0);
      rst = 1'b0;
      tick();

      // HALT, core halts 3 cycles later
      issue(OP_HALT, 12'd0, 32'd0);
      chk("halt_req_c1", {31'd0, halt_req}, 32'd1);
      chk("halt_busy_c1", {31'd0, busy}, 32'd1);
      for (int c = 1; c <= 5; c++) begin
         chk("halt_rsp_valid", {31'd0, rsp_valid}, (c == 4) ? 32'd1 : 32'd0);
         if (c == 4) chk("halt_rsp_err", {31'd0, rsp_err}, 32'd0);
         if (c == 3) halted = 1'b1;
         if (c < 5) tick();
      end
      chk("halt_req_hold", {31'd0, halt_req}, 32'd1);

      // RF_WR 5 <= DEADBEEF
      issue(OP_RF_WR, 12'd5, 32'hDEADBEEF);
      chk("rfwr_strobe", {31'd0, rf_write}, 32'd1);
      chk("rfwr_addr", {27'd0, rf_addr}, 32'd5);
      chk("rfwr_wd", rf_wd, 32'hDEADBEEF);
      chk("rfwr_rsp_c1", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("rfwr_strobe_c2", {31'd0, rf_write}, 32'd0);
      chk("rfwr_rsp_c2", {30'd0, rsp_valid, rsp_err}, 32'd2);
      tick();

      // RF_RD 5
      issue(OP_RF_RD, 12'd5, 32'd0);
      chk("rfrd_addr", {27'd0, rf_addr}, 32'd5);
      chk("rfrd_nostrobe", {31'd0, rf_write}, 32'd0);
      chk("rfrd_rsp_c1", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("rfrd_rsp_c2", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("rfrd_rsp_c3", {30'd0, rsp_valid, rsp_err}, 32'd2);
      chk("rfrd_rdata", rsp_rdata, 32'hDEADBEEF);
      tick();

      // CSR_WR 0x305 then CSR_RD 0x341
      issue(OP_CSR_WR, 12'h305, 32'h12345678);
      chk("csrwr_strobe", {31'd0, csr_write}, 32'd1);
      chk("csrwr_addr", {20'd0, csr_addr}, 32'h305);
      chk("csrwr_wd", csr_wd, 32'h12345678);
      tick();
      chk("csrwr_rsp_c2", {29'd0, rsp_valid, rsp_err, csr_write}, 32'd4);
      tick();
      issue(OP_CSR_RD, 12'h341, 32'd0);
      tick();
      tick();
      chk("csrrd_rsp_c3", {30'd0, rsp_valid, rsp_err}, 32'd2);
      chk("csrrd_rdata", rsp_rdata, 32'hC5A00341);
      tick();

      // RF_WR x0: no strobe, no error
      issue(OP_RF_WR, 12'd0, 32'h55);
      chk("rfwr0_nostrobe", {31'd0, rf_write}, 32'd0);
      tick();
      chk("rfwr0_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
      tick();

      // RF_RD with out-of-range index
      issue(OP_RF_RD, 12'h020, 32'd0);
      chk("rfrd_bad_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
      chk("rfrd_bad_nostrobe", {31'd0, rf_write}, 32'd0);
      tick();

      // Reserved op; read data holds from the last read
      issue(OP_RSVD, 12'd0, 32'd0);
      chk("rsvd_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
      chk("rsvd_rdata_hold", rsp_rdata, 32'hC5A00341);
      tick();

      // RESUME, core leaves halt after one wait cycle
      issue(OP_RESUME, 12'd0, 32'd0);
      chk("resume_req_c1", {31'd0, halt_req}, 32'd0);
      chk("resume_rsp_c1", {31'd0, rsp_valid}, 32'd0);
      tick();
      halted = 1'b0;
      chk("resume_rsp_c2", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("resume_rsp_c3", {30'd0, rsp_valid, rsp_err}, 32'd2);
      tick();

      // CSR_RD with core running: error, ports untouched
      issue(OP_CSR_RD, 12'h300, 32'd0);
      chk("csr_run_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
      chk("csr_run_addr", {20'd0, csr_addr}, 32'h341);
      chk("csr_run_strobes", {30'd0, csr_write, rf_write}, 32'd0);
      tick();

      // HALT with core never halting: timeout after 4 wait counts
      issue(OP_HALT, 12'd0, 32'd0);
      for (int c = 1; c <= 7; c++) begin
         chk("to_rsp_valid", {31'd0, rsp_valid}, (c == 6) ? 32'd1 : 32'd0);
         if (c == 5) chk("to_req_c5", {31'd0, halt_req}, 32'd1);
         if (c == 6) chk("to_err_req_c6", {30'd0, rsp_err, halt_req}, 32'd2);
         if (c == 7) chk("to_ready_c7", {31'd0, cmd_ready}, 32'd1);
         if (c < 7) tick();
      end

      // Immediate HALT with core already halted
      halted = 1'b1;
      issue(OP_HALT, 12'd0, 32'd0);
      chk("halt_imm_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
      chk("halt_imm_req", {31'd0, halt_req}, 32'd1);
      tick();

      // Reset during READ of a CSR_RD
      issue(OP_CSR_RD, 12'h7B0, 32'd0);
      chk("rstmid_addr", {20'd0, csr_addr}, 32'h7B0);
      tick();
      chk("rstmid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid_ctrl", {26'd0, busy, rsp_valid, rsp_err, halt_req, rf_write, csr_write}, 32'd0);
      chk("rstmid_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rstmid_rdata", rsp_rdata, 32'd0);
      chk("rstmid_csraddr", {20'd0, csr_addr}, 32'd0);
      chk("rstmid_csrwd", csr_wd, 32'd0);
      chk("rstmid_rf", {rf_addr, 27'd0} | {5'd0, 27'(rf_wd != 32'd0)}, 32'd0);
      tick();
      chk("rstmid_norsp", {31'd0, rsp_valid}, 32'd0);
      rst = 1'b0;
      tick();
      chk("rstmid_norsp2", {31'd0, rsp_valid}, 32'd0);

      // NOP after reset release
      issue(OP_NOP, 12'd0, 32'd0);
      chk("nop_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
      tick();
      chk("nop_rsp_done", {31'd0, rsp_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
